// File: rtl/neuron_accum_ctrl.sv
// rtl/neuron_accum_ctrl.sv - sequencing controller folding N_TERMS products into a bias via an external FP adder
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   clear               synchronous abort back to IDLE (wins over start)
//   start, bias         begin an evaluation, bias captured on the accepting edge
//   term_valid/ready    product handshake; term_data is the product, term_sub selects subtract
//   fpu_a/fpu_b/fpu_sub operands and op select driven to the shared combinational adder
//   fpu_result          adder result, registered into the accumulator on each accepted term
//   sum_valid/ready     final-sum handshake; sum_data/sum_exc carry the sum and sticky exponent-255 flag
//   busy                high whenever the controller is not idle

module neuron_accum_ctrl #(
    parameter int N_TERMS = 8,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] bias,
    input  logic        term_valid,
    input  logic [31:0] term_data,
    input  logic        term_sub,
    output logic        term_ready,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic        fpu_sub,
    input  logic [31:0] fpu_result,
    output logic        sum_valid,
    output logic [31:0] sum_data,
    output logic        sum_exc,
    input  logic        sum_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    state_t           state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             exc_q, exc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= 32'h0;
            cnt_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            exc_q   <= exc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        exc_d      = exc_q;
        term_ready = 1'b0;
        sum_valid  = 1'b0;
        fpu_a      = acc_q;
        fpu_b      = 32'h0;
        fpu_sub    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = bias;
                    cnt_d   = '0;
                    exc_d   = (bias[30:23] == 8'hFF);
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                // term_ready is purely state-derived so there is no
                // combinational loop through the producer's valid.
                term_ready = 1'b1;
                fpu_b      = term_data;
                fpu_sub    = term_sub;
                if (term_valid) begin
                    acc_d = fpu_result;
                    cnt_d = cnt_q + CNT_W'(1);
                    exc_d = exc_q | (term_data[30:23] == 8'hFF)
                                  | (fpu_result[30:23] == 8'hFF);
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                sum_valid = 1'b1;
                if (sum_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything, including a start seen in IDLE.
        if (clear) begin
            state_d = S_IDLE;
            acc_d   = 32'h0;
            cnt_d   = '0;
            exc_d   = 1'b0;
        end
    end

    assign sum_data = acc_q;
    assign sum_exc  = exc_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: doc/neuron_accum_ctrl.md
# neuron_accum_ctrl

Sequencing controller for the shared combinational IEEE-754 single-precision add/sub unit inside a neuron. It loads a bias into an accumulator register, then streams in N_TERMS weighted products over a valid/ready handshake. Each accepted product is folded into the accumulator through the external adder in one cycle. The final sum is presented on a valid/ready output port. The adder stays outside this block; the controller drives its operands and operation select and registers its result.

## Interface
- N_TERMS, 8, products accumulated per neuron evaluation; must be ≥1.
- CNT_W, 4, term counter width; must satisfy 2^CNT_W > N_TERMS.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous abort; returns the block to IDLE from any state.
- start  in  1  begin an evaluation; honoured only in IDLE.
- bias  in  32  IEEE-754 bias; captured on the start-accept edge.
- term_valid  in  1  product available.
- term_data  in  32  IEEE-754 product.
- term_sub  in  1  1 = subtract this term, 0 = add it.
- term_ready  out  1  controller accepts a term this cycle.
- fpu_a  out  32  adder operand a.
- fpu_b  out  32  adder operand b.
- fpu_sub  out  1  adder select: 0 = add, 1 = subtract.
- fpu_result  in  32  combinational adder result, valid in the same cycle.
- sum_valid  out  1  final sum available.
- sum_data  out  32  final sum.
- sum_exc  out  1  sticky flag: an exponent of 255 was seen during this evaluation.
- sum_ready  in  1  consumer takes the sum.
- busy  out  1  high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, ACCUM, DONE. The accumulator register is acc[31:0]; the term counter is cnt[CNT_W-1:0]; exc is a 1-bit sticky flag.
- **IDLE:** term_ready=0, sum_valid=0. If start=1 and clear=0: acc<=bias, cnt<=0, exc<=(bias[30:23]==8'hFF), and the FSM moves to ACCUM.
- **ACCUM:** term_ready=1, fpu_a=acc, fpu_b=term_data, fpu_sub=term_sub. On term_valid&term_ready:
  - acc<=fpu_result and cnt<=cnt+1.
  - exc<=exc | (term_data[30:23]==8'hFF) | (fpu_result[30:23]==8'hFF).
  - If cnt==N_TERMS-1, the FSM moves to DONE.
  - With no term_valid, all state holds (bubble).
- **DONE:** sum_valid=1, sum_data=acc, sum_exc=exc, term_ready=0. On sum_ready=1 the FSM moves to IDLE. acc and exc hold until the next start.
- **Adder drive outside ACCUM:** fpu_a=acc, fpu_b=32'h0, fpu_sub=0.
- sum_data=acc and sum_exc=exc in every state, but they are meaningful only while sum_valid=1.
- start in ACCUM or DONE is ignored; it is not queued.
- clear=1 in any state: the FSM goes to IDLE, and acc, cnt and exc go to 0. If clear and start are asserted in the same cycle, clear wins.
- Rounding and special-value handling are whatever the adder produces; the controller never modifies fpu_result.

## Timing
- **Reset values:** state=IDLE, acc=0, cnt=0, exc=0. This gives term_ready=0, sum_valid=0, busy=0, sum_data=0, sum_exc=0, fpu_a=0, fpu_b=0, fpu_sub=0.
- **Asynchronous reset mid-operation:** an assertion mid-evaluation discards it immediately. No sum is produced.
- **Start:** start is accepted on edge t. busy and term_ready go high at t+1.
- **Throughput:** one term per cycle. With term_valid held high, the last term is accepted on edge t+N_TERMS and sum_valid rises at t+N_TERMS+1.
- **Output hold:** sum_valid and sum_data stay stable until sum_ready is sampled high. sum_valid falls on the next cycle.
- **Back-to-back evaluations:** the earliest next start is accepted in the cycle after the DONE→IDLE transition. The minimum evaluation period is therefore N_TERMS+2 cycles.
- **Combinational paths:** term_ready depends only on state; there is no combinational path from term_valid. The only combinational input-to-output paths are term_data/term_sub → fpu_b/fpu_sub and fpu_result → acc D-input.

## Test plan
- **Basic add:** N_TERMS=4, bias=0x3F800000, four terms 0x3F800000 with term_sub=0, term_valid held high → sum_valid rises 5 cycles after the start edge, sum_data=0x40A00000 (5.0), sum_exc=0.
- **Mixed add/sub:** bias=0x40000000, terms +0x3F800000, −0x3F000000, +0x3FC00000, −0x3F800000 → sum_data=0x40400000 (3.0).
- **Bubbles and backpressure:** repeat the basic add with term_valid low on alternate cycles and sum_ready held low for 3 cycles → same sum; acc and cnt hold during bubbles; sum_valid and sum_data stable until sum_ready, then IDLE the next cycle.
- **Ignored start:** pulse start in ACCUM and in DONE → no effect; only one sum produced.
- **Clear and reset mid-evaluation:**
  - clear after 2 terms → IDLE next cycle, acc=0, no sum_valid.
  - A simultaneous clear+start in IDLE → stays IDLE.
  - rst mid-ACCUM → all outputs at reset values immediately.
- **Exception:** one term=0x7F800000 → sum_exc=1 at DONE. A following clean evaluation → sum_exc=0.
